// File: rtl/carga_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// No logic of its own; constants are sized for a 32-bit instruction word.
// Optional checksum feature is selected by CARGA_CHECKSUM_EN in carga_instrucciones.
package carga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    LATCH,
    WRITE,
    DONE
  } estado_t;

  localparam logic [31:0] HALT_WORD         = 32'hFFFFFFFF;
  localparam int          BYTES_POR_PALABRA = 4;
  localparam int          ADDR_STEP         = 4;

endpackage

// File: rtl/carga_ensamblador.sv
// Big-endian byte-to-word assembler: the first byte shifted in ends up as the MSB.
// o_palabra/o_completa are combinational on the 4th byte so the word is captured on that edge.
// No backpressure: every i_shift pulse consumes i_byte.
module carga_ensamblador
  import carga_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int NBYTE = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic [NBYTE-1:0] i_byte,
  output logic [NBITS-1:0] o_palabra,
  output logic             o_completa
);

  // Bytes already received for the word in progress, oldest in the upper bits.
  logic [NBITS-NBYTE-1:0] previos;
  logic [1:0]             cuenta;

  assign o_palabra  = {previos, i_byte};
  assign o_completa = i_shift && (cuenta == 2'(BYTES_POR_PALABRA - 1));

  // Shift register and byte counter; the counter wraps to 0 after the 4th byte.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      previos <= '0;
      cuenta  <= '0;
    end else if (i_clr) begin
      previos <= '0;
      cuenta  <= '0;
    end else if (i_shift) begin
      previos <= o_palabra[NBITS-NBYTE-1:0];
      cuenta  <= cuenta + 2'd1;
    end
  end

endmodule

// File: rtl/carga_instrucciones.sv
// Loads a program byte stream into instruction memory, one 32-bit word every 4 bytes (macro CARGA_CHECKSUM_EN adds a trailing XOR checksum byte).
// Latency: write strobe rises 2 cycles after the 4th byte strobe (one setup cycle in LATCH, one write cycle).
// No backpressure: bytes arriving during LATCH/WRITE are dropped and set the sticky o_Error.
module carga_instrucciones
  import carga_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int CELDAS = 256,
  parameter int NBYTE  = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Start,
  input  logic [NBYTE-1:0] i_Dato,
  input  logic             i_DatoValid,
  output logic [NBITS-1:0] o_DirecDebug,
  output logic [NBITS-1:0] o_DatoDebug,
  output logic             o_WriteDebug,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Error
);

  estado_t          estado, estado_sig;
  logic             clr, shift_en, carga_dato, err_set, avanzar_dir;
  logic [NBITS-1:0] palabra;
  logic             completa;
  logic             es_halt, ultima_dir;

`ifdef CARGA_CHECKSUM_EN
  logic             esperando_chk;
  logic             chk_fin;
  logic [NBYTE-1:0] xor_acc;
`endif

  carga_ensamblador #(
    .NBITS (NBITS),
    .NBYTE (NBYTE)
  ) u_ensamblador (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (clr),
    .i_shift    (shift_en),
    .i_byte     (i_Dato),
    .o_palabra  (palabra),
    .o_completa (completa)
  );

  assign es_halt    = (o_DatoDebug == NBITS'(HALT_WORD));
  assign ultima_dir = (o_DirecDebug == NBITS'(CELDAS - ADDR_STEP));

  // Outputs decoded from state so an asynchronous reset drops the write strobe at once.
  assign o_WriteDebug = (estado == WRITE);
  assign o_Busy       = (estado == RECV) || (estado == LATCH) || (estado == WRITE);
  assign o_Done       = (estado == DONE);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) estado <= IDLE;
    else          estado <= estado_sig;
  end

  // Next-state and datapath control strobes.
  always_comb begin
    estado_sig  = estado;
    clr         = 1'b0;
    shift_en    = 1'b0;
    carga_dato  = 1'b0;
    err_set     = 1'b0;
    avanzar_dir = 1'b0;
`ifdef CARGA_CHECKSUM_EN
    chk_fin     = 1'b0;
`endif
    case (estado)
      IDLE: begin
        if (i_Start) begin
          clr        = 1'b1;
          estado_sig = RECV;
        end
      end
      RECV: begin
        if (i_DatoValid) begin
`ifdef CARGA_CHECKSUM_EN
          if (esperando_chk) begin
            chk_fin    = 1'b1;
            err_set    = (i_Dato != xor_acc);
            estado_sig = DONE;
          end else begin
            shift_en = 1'b1;
            if (completa) begin
              carga_dato = 1'b1;
              estado_sig = LATCH;
            end
          end
`else
          shift_en = 1'b1;
          if (completa) begin
            carga_dato = 1'b1;
            estado_sig = LATCH;
          end
`endif
        end
      end
      LATCH: begin
        err_set    = i_DatoValid;
        estado_sig = WRITE;
      end
      WRITE: begin
        err_set     = i_DatoValid;
        avanzar_dir = 1'b1;
        if (es_halt) begin
`ifdef CARGA_CHECKSUM_EN
          estado_sig = RECV;
`else
          estado_sig = DONE;
`endif
        end else if (ultima_dir) begin
          err_set    = 1'b1;
          estado_sig = DONE;
        end else begin
          estado_sig = RECV;
        end
      end
      DONE: begin
        if (!i_Start) estado_sig = IDLE;
      end
      default: estado_sig = IDLE;
    endcase
  end

  // Address, write data and sticky error; address/data hold steady through LATCH and WRITE.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_DirecDebug <= '0;
      o_DatoDebug  <= '0;
      o_Error      <= 1'b0;
    end else begin
      if (clr) begin
        o_DirecDebug <= '0;
        o_Error      <= 1'b0;
      end else begin
        if (avanzar_dir) o_DirecDebug <= o_DirecDebug + NBITS'(ADDR_STEP);
        if (err_set)     o_Error      <= 1'b1;
      end
      if (carga_dato) o_DatoDebug <= palabra;
    end
  end

`ifdef CARGA_CHECKSUM_EN
  // Running XOR of program bytes and the wait-for-checksum flag armed by the halt write.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      esperando_chk <= 1'b0;
      xor_acc       <= '0;
    end else if (clr) begin
      esperando_chk <= 1'b0;
      xor_acc       <= '0;
    end else begin
      if (shift_en)              xor_acc       <= xor_acc ^ i_Dato;
      if (avanzar_dir && es_halt) esperando_chk <= 1'b1;
      if (chk_fin)               esperando_chk <= 1'b0;
    end
  end
`endif

endmodule
